// File: rtl/tt_csr_regfile_if.sv
// CSB request/response bundle between the AXI-lite->CSB bridge and the TT CSR bank.
// Request: vld/rdy handshake. Response: single-cycle pulse with no back-pressure.
interface tt_csr_regfile_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic                     csb2tt_req_vld;
  logic                     csb2tt_req_rdy;
  logic [ADDR_W+DATA_W:0]   csb2tt_req_pd;
  logic                     tt2csb_resp_vld;
  logic [DATA_W-1:0]        tt2csb_resp_pd;

  modport master (
    output csb2tt_req_vld,
    output csb2tt_req_pd,
    input  csb2tt_req_rdy,
    input  tt2csb_resp_vld,
    input  tt2csb_resp_pd
  );

  modport slave (
    input  csb2tt_req_vld,
    input  csb2tt_req_pd,
    output csb2tt_req_rdy,
    output tt2csb_resp_vld,
    output tt2csb_resp_pd
  );
endinterface

// File: rtl/tt_csr_regfile.sv
// CSR bank for the FC Tensor-Train path: decodes CSB packets, holds layer config,
// sequences the TT core start/done handshake and raises the done interrupt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | core idle; OP_EN may launch an operation, cfg writes accepted
// ST_BUSY | operation in flight; cfg writes and OP_EN ignored until done
module tt_csr_regfile #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h5454_0001
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_csr_regfile_if.slave     csb,
  output logic                tt_op_start,
  input  logic                tt_op_done,
  output logic [DATA_W-1:0]   cfg_in_base,
  output logic [DATA_W-1:0]   cfg_out_base,
  output logic [DATA_W-1:0]   cfg_wt_base,
  output logic [3:0]          cfg_core_num,
  output logic [7:0]          cfg_rank,
  output logic                tt_intr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [ADDR_W-1:0] A_TT_ID    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_OP_EN    = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_INT_CLR  = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_IN_BASE  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_OUT_BASE = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] A_WT_BASE  = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] A_CORE_NUM = ADDR_W'(8'h07);
  localparam logic [ADDR_W-1:0] A_RANK     = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_INT_EN   = ADDR_W'(8'h09);

  logic [0:0]         op_state;
  logic               busy;
  logic               done;
  logic               int_en;
  logic               req_rdy;

  logic               pd_wr;
  logic [ADDR_W-1:0]  pd_addr;
  logic [DATA_W-1:0]  pd_wdata;
  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic               start_req;
  logic               cfg_we;
  logic               done_set;
  logic               done_clr;
  logic [DATA_W-1:0]  rd_data;

  assign pd_wr    = csb.csb2tt_req_pd[ADDR_W+DATA_W];
  assign pd_addr  = csb.csb2tt_req_pd[ADDR_W+DATA_W-1:DATA_W];
  assign pd_wdata = csb.csb2tt_req_pd[DATA_W-1:0];

  assign accept = csb.csb2tt_req_vld & req_rdy;
  assign wr_en  = accept & pd_wr;
  assign rd_en  = accept & ~pd_wr;
  assign busy   = (op_state == ST_BUSY);

  assign start_req = wr_en & (pd_addr == A_OP_EN) & pd_wdata[0] & ~busy;
  // Config is frozen while the core runs so it sees one consistent layer setup.
  assign cfg_we    = wr_en & ~busy;
  assign done_set  = tt_op_done & busy;
  assign done_clr  = wr_en & (pd_addr == A_INT_CLR) & pd_wdata[0];

  assign csb.csb2tt_req_rdy = req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rdy <= 1'b0;
    end else begin
      req_rdy <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_state <= ST_IDLE;
    end else begin
      case (op_state)
        ST_IDLE: if (start_req)  op_state <= ST_BUSY;
        ST_BUSY: if (tt_op_done) op_state <= ST_IDLE;
        default:                 op_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_op_start <= 1'b0;
    end else begin
      tt_op_start <= start_req;
    end
  end

  // A completion arriving together with a W1C write must not be lost: set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (done_set) begin
      done <= 1'b1;
    end else if (done_clr) begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_en  <= 1'b0;
      tt_intr <= 1'b0;
    end else begin
      if (wr_en && (pd_addr == A_INT_EN)) begin
        int_en <= pd_wdata[0];
      end
      tt_intr <= done & int_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_in_base  <= '0;
      cfg_out_base <= '0;
      cfg_wt_base  <= '0;
      cfg_core_num <= '0;
      cfg_rank     <= '0;
    end else if (cfg_we) begin
      case (pd_addr)
        A_IN_BASE:  cfg_in_base  <= pd_wdata;
        A_OUT_BASE: cfg_out_base <= pd_wdata;
        A_WT_BASE:  cfg_wt_base  <= pd_wdata;
        A_CORE_NUM: cfg_core_num <= pd_wdata[3:0];
        A_RANK:     cfg_rank     <= pd_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (pd_addr)
      A_TT_ID:    rd_data = ID_VALUE;
      A_OP_EN:    rd_data = {{(DATA_W-1){1'b0}}, busy};
      A_STATUS:   rd_data = {{(DATA_W-2){1'b0}}, done, busy};
      A_INT_CLR:  rd_data = '0;
      A_IN_BASE:  rd_data = cfg_in_base;
      A_OUT_BASE: rd_data = cfg_out_base;
      A_WT_BASE:  rd_data = cfg_wt_base;
      A_CORE_NUM: rd_data = {{(DATA_W-4){1'b0}}, cfg_core_num};
      A_RANK:     rd_data = {{(DATA_W-8){1'b0}}, cfg_rank};
      A_INT_EN:   rd_data = {{(DATA_W-1){1'b0}}, int_en};
      default:    rd_data = '0;
    endcase
  end

  // Data is forced to zero outside the valid cycle so the bridge can OR responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb.tt2csb_resp_vld <= 1'b0;
      csb.tt2csb_resp_pd  <= '0;
    end else begin
      csb.tt2csb_resp_vld <= rd_en;
      csb.tt2csb_resp_pd  <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: doc/tt_csr_regfile.md
Name: tt_csr_regfile

Overview:
- Slave-side CSR register bank for the FC Tensor-Train path, directly downstream of the AXI-lite→CSB bridge.
- Consumes CSB request packets on the TT port (local word addresses 0..63) and returns read data on the one-cycle response channel.
- Drives layer configuration, the start pulse and the interrupt for the TT compute core.

Parameters:
ADDR_W, 9, width of CSB word-address field
DATA_W, 32, register/data width
ID_VALUE, 32'h5454_0001, constant returned by TT_ID register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
csb2tt_req_vld  in  1  request valid
csb2tt_req_rdy  out  1  request ready
csb2tt_req_pd  in  ADDR_W+DATA_W+1 (42)  packet: [41] wr (1=write), [40:32] local word addr, [31:0] wdata
tt2csb_resp_vld  out  1  read-response valid, single-cycle pulse, no back-pressure
tt2csb_resp_pd  out  32  read data
tt_op_start  out  1  one-cycle start pulse to TT core
tt_op_done  in  1  one-cycle completion pulse from TT core
cfg_in_base  out  32  input tensor base address
cfg_out_base  out  32  output base address
cfg_wt_base  out  32  TT-core weight base address
cfg_core_num  out  4  number of TT cores
cfg_rank  out  8  TT rank
tt_intr  out  1  level interrupt, registered

Behaviour:
- Reset values: all outputs 0, including csb2tt_req_rdy. All cfg registers, busy, done and int_en are 0.
- First cycle after reset release: csb2tt_req_rdy goes 1 and stays 1; the block never stalls.
- Accept: a request is accepted on any posedge with req_vld & req_rdy. Fields are decoded from pd at that edge.
- Read response:
  - resp_vld=1 in the cycle immediately after acceptance, for exactly one cycle; resp_pd holds the data.
  - resp_pd returns 0 whenever resp_vld=0.
  - Back-to-back reads give back-to-back responses.
- Writes produce no response. Register updates are visible to reads accepted on the next cycle.
- Register map (local word address):
  - 0x00 TT_ID: RO, returns ID_VALUE.
  - 0x01 OP_EN: write with wdata[0]=1 while busy=0 → tt_op_start=1 the next cycle (one cycle) and busy←1. Write while busy → ignored. Read returns {31'b0,busy}.
  - 0x02 STATUS: RO, {30'b0, done, busy}.
  - 0x03 INT_CLR: write wdata[0]=1 → done←0 (W1C). Read returns 0.
  - 0x04 IN_BASE, 0x05 OUT_BASE, 0x06 WT_BASE: RW, 32 bits.
  - 0x07 CORE_NUM: RW [3:0]. 0x08 RANK: RW [7:0]. Unused bits are ignored on write and read as 0.
  - 0x09 INT_EN: RW bit0.
  - Any other address: reads return 0, writes are ignored.
- Config lock: writes to 0x04–0x08 while busy=1 are ignored, so cfg outputs are stable for the whole operation.
- Done handling: tt_op_done while busy → busy←0, done←1. tt_op_done while idle is ignored.
- Simultaneous done pulse and INT_CLR write in the same cycle: set wins, done=1.
- Interrupt: tt_intr is registered, = done & int_en, with one cycle of latency after either input changes.
- Reset mid-operation: busy, done and pending start/response all clear immediately. Any in-flight read response is dropped.

Test Plan:
- Reset, then read 0x00 → one cycle later resp_vld=1, resp_pd=0x54540001. Read 0x3F → resp_pd=0.
- Write 0x04=0x1000_0000, 0x07=0xFF, 0x08=0x20, then read each → 0x10000000, 0x0000000F, 0x00000020. cfg outputs match.
- Write 0x01=1 → tt_op_start high one cycle and STATUS=0x1. A second OP_EN write produces no pulse. Write 0x04=0xDEAD while busy → read still 0x10000000.
- INT_EN=1, pulse tt_op_done → STATUS=0x2 and tt_intr=1 one cycle after done. Write 0x03=1 → STATUS=0x0 and tt_intr=0.
- tt_op_done in the same cycle as an INT_CLR write → STATUS=0x2 and tt_intr stays 1.
- Four back-to-back reads (0x00, 0x04, 0x02, 0x08) → four consecutive resp_vld cycles with matching data.
- Assert rst_n low while busy → all outputs 0 asynchronously. After release, STATUS=0.
